aes_key_expand_128: RTL and testbench

AES-128 key-expansion and round-key sequencer feeding the `key_round` input of the 3-cycle-round encryption core. A cipher key is loaded once and expanded into 11 round keys (K0..K10), which are held in a register file. On each `input_en` the block replays K0..K10 on `key_round`, one key per 3-cycle core round, aligned with the core's AddRoundKey sampling.

---
 rtl/aes_key_expand_128.sv | 212 +++++++++++++++++++++
 tb/tb_aes_key_expand_128.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand_128.sv
// AES-128 key expansion into an 11-entry round-key file, plus the replay
// sequencer that presents K0..K10 on key_round, one key per cipher-core round.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no expansion running; round keys valid when key_ready=1
// SUB   | S-box reads issued on RotWord(w3) of the previous round key
// XOR   | next round key formed from the S-box result and stored
module aes_key_expand_128 #(
    parameter        SBOX_FILE  = "sbox.hex",
    parameter int    ROUND_CLKS = 3
) (
    input  logic         clk,
    input  logic         kill_n,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic         input_en,
    output logic [127:0] key_round,
    output logic         key_ready,
    output logic         key_busy,
    output logic         key_err
);

    // The S-box is built from GF(2^8) inversion plus the affine map, so no
    // image file is read; SBOX_FILE stays so existing instantiations elaborate.
    if (ROUND_CLKS < 2 || ROUND_CLKS > 4 || $bits(SBOX_FILE) == 0) begin : g_param_check
        $error("aes_key_expand_128: ROUND_CLKS must be 2..4");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_XOR  = 2'd2
    } state_t;

    localparam logic [1:0] CNT_LOAD = 2'(ROUND_CLKS - 1);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x3;
        logic [7:0] x7;
        logic [7:0] x15;
        logic [7:0] x31;
        logic [7:0] x63;
        logic [7:0] x127;
        x3   = gf_mul(gf_mul(a, a), a);
        x7   = gf_mul(gf_mul(x3, x3), a);
        x15  = gf_mul(gf_mul(x7, x7), a);
        x31  = gf_mul(gf_mul(x15, x15), a);
        x63  = gf_mul(gf_mul(x31, x31), a);
        x127 = gf_mul(gf_mul(x63, x63), a);
        return gf_mul(x127, x127);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    state_t         state_q, state_d;
    logic [3:0]     rnd_q;
    logic [7:0]     rcon_q;
    logic [127:0]   work_q;
    logic [31:0]    sbox_q;
    logic [127:0]   rk_q [0:10];
    logic           ready_q;
    logic           busy_q;
    logic           err_q;
    logic           act_q;
    logic [3:0]     idx_q;
    logic [1:0]     cnt_q;

    logic [31:0]    rot_w;
    logic [31:0]    sub_w;
    logic [31:0]    t_w;
    logic [31:0]    w0_n, w1_n, w2_n, w3_n;
    logic [127:0]   key_next;
    logic [3:0]     sel_idx;

    assign rot_w = {work_q[23:16], work_q[15:8], work_q[7:0], work_q[31:24]};
    assign sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                    sbox(rot_w[15:8]),  sbox(rot_w[7:0])};

    assign t_w      = sbox_q ^ {rcon_q, 24'h000000};
    assign w0_n     = work_q[127:96] ^ t_w;
    assign w1_n     = work_q[95:64]  ^ w0_n;
    assign w2_n     = work_q[63:32]  ^ w1_n;
    assign w3_n     = work_q[31:0]   ^ w2_n;
    assign key_next = {w0_n, w1_n, w2_n, w3_n};

    always_comb begin
        state_d = state_q;
        if (key_load) begin
            state_d = ST_SUB;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_SUB:  state_d = ST_XOR;
                ST_XOR:  state_d = (rnd_q == 4'd10) ? ST_IDLE : ST_SUB;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            rnd_q   <= 4'd0;
            rcon_q  <= 8'h00;
            work_q  <= '0;
            sbox_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i <= 10; i++) rk_q[i] <= '0;
        end else if (key_load) begin
            work_q  <= key_in;
            rk_q[0] <= key_in;
            rcon_q  <= 8'h01;
            rnd_q   <= 4'd1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_SUB: sbox_q <= sub_w;
                ST_XOR: begin
                    work_q <= key_next;
                    for (int i = 1; i <= 10; i++) begin
                        if (rnd_q == 4'(i)) rk_q[i] <= key_next;
                    end
                    rcon_q <= xtime(rcon_q);
                    if (rnd_q == 4'd10) begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Replay: K0 is shown combinationally in the input_en cycle, so the
    // registered index starts at K1; cnt_q is a per-round down-counter.
    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            act_q <= 1'b0;
            idx_q <= 4'd0;
            cnt_q <= 2'd0;
            err_q <= 1'b0;
        end else begin
            err_q <= input_en && !ready_q;
            if (key_load) begin
                act_q <= 1'b0;
                idx_q <= 4'd0;
                cnt_q <= 2'd0;
            end else if (input_en && ready_q) begin
                act_q <= 1'b1;
                idx_q <= 4'd1;
                cnt_q <= CNT_LOAD;
            end else if (act_q) begin
                if (cnt_q == 2'd0) begin
                    cnt_q <= CNT_LOAD;
                    if (idx_q == 4'd10) begin
                        act_q <= 1'b0;
                        idx_q <= 4'd0;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end else begin
                    cnt_q <= cnt_q - 2'd1;
                end
            end
        end
    end

    always_comb begin
        sel_idx = 4'd0;
        if (!input_en && act_q) sel_idx = idx_q;
        key_round = ready_q ? rk_q[sel_idx] : '0;
    end

    assign key_ready = ready_q;
    assign key_busy  = busy_q;
    assign key_err   = err_q;

endmodule

// File: tb/tb_aes_key_expand_128.sv
// Scoreboard bench for aes_key_expand_128: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_aes_key_expand_128;

    localparam int SIG_ROUND = 0;
    localparam int SIG_READY = 1;
    localparam int SIG_BUSY  = 2;
    localparam int SIG_ERR   = 3;

    logic         clk = 1'b0;
    logic         kill_n = 1'b1;
    logic [127:0] key_in = '0;
    logic         key_load = 1'b0;
    logic         input_en = 1'b0;
    logic [127:0] key_round;
    logic         key_ready;
    logic         key_busy;
    logic         key_err;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    int           q_cyc [$];
    int           q_sig [$];
    logic [127:0] q_val [$];

    logic [127:0] ka [0:10];
    logic [127:0] kz1;
    logic [127:0] kz10;

    aes_key_expand_128 dut (
        .clk       (clk),
        .kill_n    (kill_n),
        .key_in    (key_in),
        .key_load  (key_load),
        .input_en  (input_en),
        .key_round (key_round),
        .key_ready (key_ready),
        .key_busy  (key_busy),
        .key_err   (key_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [127:0] sig_val(input int s);
        case (s)
            SIG_ROUND: return key_round;
            SIG_READY: return {127'd0, key_ready};
            SIG_BUSY:  return {127'd0, key_busy};
            default:   return {127'd0, key_err};
        endcase
    endfunction

    function automatic string sig_name(input int s);
        case (s)
            SIG_ROUND: return "key_round";
            SIG_READY: return "key_ready";
            SIG_BUSY:  return "key_busy";
            default:   return "key_err";
        endcase
    endfunction

    task automatic expect_at(input int c, input int s, input logic [127:0] v);
        q_cyc.push_back(c);
        q_sig.push_back(s);
        q_val.push_back(v);
    endtask

    always @(negedge clk) begin
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            if (q_cyc[0] < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL late_%s due=%0d now=%0d", sig_name(q_sig[0]), q_cyc[0], cyc);
            end else begin
                check(sig_name(q_sig[0]), sig_val(q_sig[0]), q_val[0]);
            end
            void'(q_cyc.pop_front());
            void'(q_sig.pop_front());
            void'(q_val.pop_front());
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // key_load at cycle L: busy from L+1 through L+20, ready and K0 from L+21.
    task automatic expect_expansion(input int l, input logic [127:0] k0);
        expect_at(l + 1,  SIG_BUSY,  128'd1);
        expect_at(l + 20, SIG_BUSY,  128'd1);
        expect_at(l + 20, SIG_READY, 128'd0);
        expect_at(l + 20, SIG_ROUND, 128'd0);
        expect_at(l + 21, SIG_BUSY,  128'd0);
        expect_at(l + 21, SIG_READY, 128'd1);
        expect_at(l + 21, SIG_ROUND, k0);
    endtask

    // A.1 replay from input_en at T: K0 at T, Kn over three cycles, K0 after T+30.
    task automatic expect_replay(input int t, input int len);
        for (int c = 0; c < len; c++) begin
            int idx;
            if (c == 0 || c > 30) idx = 0;
            else idx = (c - 1) / 3 + 1;
            expect_at(t + c, SIG_ROUND, ka[idx]);
            if (c == 1) expect_at(t + 1, SIG_ERR, 128'd0);
        end
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
    endtask

    initial begin
        int l;
        int l2;
        int t;

        ka[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ka[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        ka[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        ka[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        ka[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        ka[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        ka[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        ka[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        ka[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        ka[9]  = 128'hac7766f319fadc2128d12941575c006e;
        ka[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        kz1    = 128'h62636363626363636263636362636363;
        kz10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        #2 kill_n = 1'b0;
        #1;
        check("rst_round", key_round, 128'd0);
        check("rst_ready", {127'd0, key_ready}, 128'd0);
        check("rst_busy",  {127'd0, key_busy},  128'd0);
        check("rst_err",   {127'd0, key_err},   128'd0);
        step(3);
        kill_n = 1'b1;
        step(2);

        // input_en with no keys: error pulse next cycle, key_round stays 0
        input_en = 1'b1;
        expect_at(cyc,     SIG_ROUND, 128'd0);
        expect_at(cyc + 1, SIG_ERR,   128'd1);
        expect_at(cyc + 2, SIG_ERR,   128'd0);
        step(1);
        input_en = 1'b0;
        step(3);

        // all-zero key on its own
        l = cyc;
        load_key(128'd0);
        expect_expansion(l, 128'd0);
        step(1);
        key_load = 1'b0;
        step(l + 23 - cyc);
        t = cyc;
        input_en = 1'b1;
        for (int c = 1; c <= 3; c++) expect_at(t + c, SIG_ROUND, kz1);
        for (int c = 28; c <= 30; c++) expect_at(t + c, SIG_ROUND, kz10);
        expect_at(t + 31, SIG_ROUND, 128'd0);
        step(1);
        input_en = 1'b0;
        step(34);

        // zero-key load aborted after 7 cycles by the A.1 key
        l = cyc;
        load_key(128'd0);
        expect_at(l + 1, SIG_BUSY,  128'd1);
        expect_at(l + 1, SIG_READY, 128'd0);
        step(1);
        key_load = 1'b0;
        step(6);
        l2 = cyc;
        load_key(ka[0]);
        expect_expansion(l2, ka[0]);
        step(1);
        key_load = 1'b0;
        step(l2 + 22 - cyc);

        // full replay alignment
        t = cyc;
        input_en = 1'b1;
        expect_replay(t, 32);
        step(1);
        input_en = 1'b0;
        step(34);

        // replay restarted 10 cycles in
        t = cyc;
        input_en = 1'b1;
        expect_replay(t, 10);
        step(1);
        input_en = 1'b0;
        step(9);
        input_en = 1'b1;
        expect_replay(cyc, 32);
        step(1);
        input_en = 1'b0;
        step(34);

        // key_load in the middle of a replay drops the keys
        t = cyc;
        input_en = 1'b1;
        expect_at(t, SIG_ROUND, ka[0]);
        step(1);
        input_en = 1'b0;
        step(4);
        expect_at(t + 5, SIG_ROUND, ka[2]);
        expect_at(t + 6, SIG_ROUND, 128'd0);
        expect_at(t + 6, SIG_READY, 128'd0);
        load_key(ka[0]);
        expect_expansion(cyc, ka[0]);
        l = cyc;
        step(1);
        key_load = 1'b0;
        step(l + 22 - cyc);

        // reset 9 cycles into an expansion
        l = cyc;
        load_key(ka[0]);
        step(1);
        key_load = 1'b0;
        step(l + 9 - cyc);
        #2 kill_n = 1'b0;
        #1;
        check("midexp_rst_busy",  {127'd0, key_busy},  128'd0);
        check("midexp_rst_ready", {127'd0, key_ready}, 128'd0);
        check("midexp_rst_round", key_round, 128'd0);
        step(1);
        kill_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            expect_at(cyc, SIG_READY, 128'd0);
            expect_at(cyc, SIG_BUSY,  128'd0);
            step(1);
        end
        l = cyc;
        load_key(ka[0]);
        expect_expansion(l, ka[0]);
        step(1);
        key_load = 1'b0;
        step(l + 22 - cyc);
        t = cyc;
        input_en = 1'b1;
        expect_replay(t, 32);
        step(1);
        input_en = 1'b0;
        step(34);

        // asynchronous reset while a replay is presenting K2
        t = cyc;
        input_en = 1'b1;
        expect_at(t, SIG_ROUND, ka[0]);
        step(1);
        input_en = 1'b0;
        step(3);
        #1;
        check("pre_rst_round", key_round, ka[2]);
        #1 kill_n = 1'b0;
        #1;
        check("async_rst_round", key_round, 128'd0);
        check("async_rst_ready", {127'd0, key_ready}, 128'd0);
        step(1);
        kill_n = 1'b1;
        step(2);
        input_en = 1'b1;
        expect_at(cyc,     SIG_ROUND, 128'd0);
        expect_at(cyc + 1, SIG_ERR,   128'd1);
        step(1);
        input_en = 1'b0;
        step(4);

        while (q_cyc.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unchecked_%s due=%0d", sig_name(q_sig[0]), q_cyc[0]);
            void'(q_cyc.pop_front());
            void'(q_sig.pop_front());
            void'(q_val.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
